uart_frame_controller: RTL and testbench

Parametrised successor UART controller. It contains complete TX and RX frame engines instead of wrapping fixed-format transmitter/receiver instances. Data length (5..DATA_UART bits), parity, stop bits and baud divisor are run-time configurable, and the receive side reports parity, framing, overrun and break conditions. It sits between the TX/RX FIFOs and the UART pins, in the fixed-clock domain of the IP core.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_baud_gen.sv | 48 ++++
 rtl/uart_frame_controller.sv | 256 +++++++++++++++++++++++++
 tb/tb_uart_frame_controller.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and helpers for the UART frame controller
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP1,
        TX_STOP2
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_e;

    typedef enum logic {
        PARITY_EVEN = 1'b0,
        PARITY_ODD  = 1'b1
    } parity_mode_e;

    localparam int MIN_DATA_LEN = 5;

    function automatic int clamp_len(input int len, input int max_len);
        if (len < MIN_DATA_LEN) return MIN_DATA_LEN;
        if (len > max_len) return max_len;
        return len;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - divisor counter producing oversample ticks and a tick phase
module uart_baud_gen #(
    parameter int DIV_SIZE   = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          en_i,
    input  logic                          restart_i,
    input  logic [DIV_SIZE-1:0]           div_i,
    output logic                          tick_o,
    output logic [$clog2(OVERSAMPLE)-1:0] tick_cnt_o
);
    localparam int CNT_W = $clog2(OVERSAMPLE);

    logic [DIV_SIZE-1:0] div_cnt_q, div_cnt_d, div_last;
    logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;

    // A divisor of zero behaves like one: every clock is a tick.
    assign div_last   = (div_i == '0) ? '0 : div_i - DIV_SIZE'(1);
    assign tick_o     = en_i && (div_cnt_q >= div_last);
    assign tick_cnt_o = tick_cnt_q;

    always_comb begin
        div_cnt_d  = div_cnt_q;
        tick_cnt_d = tick_cnt_q;
        if (!en_i || restart_i) begin
            div_cnt_d  = '0;
            tick_cnt_d = '0;
        end else if (div_cnt_q >= div_last) begin
            div_cnt_d  = '0;
            tick_cnt_d = (tick_cnt_q == CNT_W'(OVERSAMPLE - 1)) ? '0 : tick_cnt_q + CNT_W'(1);
        end else begin
            div_cnt_d = div_cnt_q + DIV_SIZE'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_controller.sv
// rtl/uart_frame_controller.sv - configurable UART TX/RX frame engines between FIFOs and pins
module uart_frame_controller #(
    parameter int DATA_UART  = 8,
    parameter int DIV_SIZE   = 16,
    parameter int OVERSAMPLE = 16,
    parameter int LEN_W      = $clog2(DATA_UART + 1)
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 uart_en_i,
    input  logic [LEN_W-1:0]     uart_data_len_i,
    input  logic                 uart_stop_bits_i,
    input  logic                 uart_parity_bit_i,
    input  logic                 uart_parity_bit_mode_i,
    input  logic [DIV_SIZE-1:0]  uart_baudrate_div_i,
    input  logic                 uart_rx_i,
    output logic                 uart_tx_o,
    input  logic                 tx_load_i,
    input  logic [DATA_UART-1:0] tx_data_i,
    output logic                 tx_pull_o,
    output logic                 tx_busy_o,
    input  logic                 rx_full_i,
    output logic [DATA_UART-1:0] rx_data_o,
    output logic                 rx_push_o,
    output logic                 rx_parity_err_o,
    output logic                 rx_frame_err_o,
    output logic                 rx_break_o,
    output logic                 rx_overrun_o
);
    import uart_pkg::*;

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] MID_TICK  = CNT_W'(OVERSAMPLE / 2 - 1);

    logic [LEN_W-1:0] len_cfg;
    logic             odd_cfg;

    assign len_cfg = LEN_W'(clamp_len(int'(uart_data_len_i), DATA_UART));
    assign odd_cfg = (parity_mode_e'(uart_parity_bit_mode_i) == PARITY_ODD);

    tx_state_e            tx_state_q;
    logic [DATA_UART-1:0] tx_shift_q;
    logic [LEN_W-1:0]     tx_bit_cnt_q, tx_len_q;
    logic [DIV_SIZE-1:0]  tx_div_q;
    logic                 tx_par_en_q, tx_par_q, tx_stop2_q;
    logic                 tx_tick, tx_bit_done, tx_last_stop, tx_accept;
    logic [CNT_W-1:0]     tx_tick_cnt;

    assign tx_bit_done  = tx_tick && (tx_tick_cnt == LAST_TICK);
    assign tx_last_stop = tx_bit_done &&
                          ((tx_state_q == TX_STOP1 && !tx_stop2_q) || tx_state_q == TX_STOP2);
    // Accepting in the last stop cycle gives gapless back-to-back frames.
    assign tx_accept    = uart_en_i && tx_load_i && (tx_state_q == TX_IDLE || tx_last_stop);

    uart_baud_gen #(.DIV_SIZE(DIV_SIZE), .OVERSAMPLE(OVERSAMPLE)) u_tx_baud (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .en_i       (uart_en_i),
        .restart_i  (tx_accept),
        .div_i      (tx_div_q),
        .tick_o     (tx_tick),
        .tick_cnt_o (tx_tick_cnt)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tx_state_q   <= TX_IDLE;
            tx_shift_q   <= '0;
            tx_bit_cnt_q <= '0;
            tx_len_q     <= '0;
            tx_div_q     <= '0;
            tx_par_en_q  <= 1'b0;
            tx_par_q     <= 1'b0;
            tx_stop2_q   <= 1'b0;
            uart_tx_o    <= 1'b1;
            tx_pull_o    <= 1'b0;
            tx_busy_o    <= 1'b0;
        end else begin
            tx_pull_o <= 1'b0;
            if (!uart_en_i) begin
                tx_state_q <= TX_IDLE;
                uart_tx_o  <= 1'b1;
                tx_busy_o  <= 1'b0;
            end else if (tx_accept) begin
                tx_state_q   <= TX_START;
                tx_shift_q   <= tx_data_i;
                tx_len_q     <= len_cfg;
                tx_div_q     <= uart_baudrate_div_i;
                tx_par_en_q  <= uart_parity_bit_i;
                tx_par_q     <= odd_cfg;
                tx_stop2_q   <= uart_stop_bits_i;
                uart_tx_o    <= 1'b0;
                tx_pull_o    <= 1'b1;
                tx_busy_o    <= 1'b1;
            end else if (tx_bit_done) begin
                case (tx_state_q)
                    TX_START: begin
                        uart_tx_o    <= tx_shift_q[0];
                        tx_par_q     <= tx_par_q ^ tx_shift_q[0];
                        tx_shift_q   <= tx_shift_q >> 1;
                        tx_bit_cnt_q <= LEN_W'(1);
                        tx_state_q   <= TX_DATA;
                    end
                    TX_DATA: begin
                        if (tx_bit_cnt_q == tx_len_q) begin
                            uart_tx_o  <= tx_par_en_q ? tx_par_q : 1'b1;
                            tx_state_q <= tx_par_en_q ? TX_PARITY : TX_STOP1;
                        end else begin
                            uart_tx_o    <= tx_shift_q[0];
                            tx_par_q     <= tx_par_q ^ tx_shift_q[0];
                            tx_shift_q   <= tx_shift_q >> 1;
                            tx_bit_cnt_q <= tx_bit_cnt_q + LEN_W'(1);
                        end
                    end
                    TX_PARITY: begin
                        uart_tx_o  <= 1'b1;
                        tx_state_q <= TX_STOP1;
                    end
                    TX_STOP1: begin
                        if (tx_stop2_q) begin
                            tx_state_q <= TX_STOP2;
                        end else begin
                            tx_state_q <= TX_IDLE;
                            tx_busy_o  <= 1'b0;
                        end
                    end
                    default: begin
                        tx_state_q <= TX_IDLE;
                        tx_busy_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

    rx_state_e            rx_state_q;
    logic [DATA_UART-1:0] rx_shift_q;
    logic [LEN_W-1:0]     rx_bit_cnt_q, rx_len_q;
    logic [DIV_SIZE-1:0]  rx_div_q;
    logic                 rx_sync1_q, rx_sync2_q, rx_prev_q;
    logic                 rx_par_en_q, rx_par_q, rx_perr_q, rx_zero_q;
    logic                 rx_tick, rx_sample, rx_fall, rx_start;
    logic [CNT_W-1:0]     rx_tick_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            rx_sync1_q <= uart_rx_i;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
        end
    end

    assign rx_fall   = rx_prev_q && !rx_sync2_q;
    assign rx_start  = uart_en_i && (rx_state_q == RX_IDLE) && rx_fall;
    // The generator is restarted on the start edge, so mid-bit is a fixed tick phase.
    assign rx_sample = rx_tick && (rx_tick_cnt == MID_TICK);

    uart_baud_gen #(.DIV_SIZE(DIV_SIZE), .OVERSAMPLE(OVERSAMPLE)) u_rx_baud (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .en_i       (uart_en_i),
        .restart_i  (rx_start),
        .div_i      (rx_div_q),
        .tick_o     (rx_tick),
        .tick_cnt_o (rx_tick_cnt)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_state_q      <= RX_IDLE;
            rx_shift_q      <= '0;
            rx_bit_cnt_q    <= '0;
            rx_len_q        <= '0;
            rx_div_q        <= '0;
            rx_par_en_q     <= 1'b0;
            rx_par_q        <= 1'b0;
            rx_perr_q       <= 1'b0;
            rx_zero_q       <= 1'b0;
            rx_data_o       <= '0;
            rx_push_o       <= 1'b0;
            rx_parity_err_o <= 1'b0;
            rx_frame_err_o  <= 1'b0;
            rx_break_o      <= 1'b0;
            rx_overrun_o    <= 1'b0;
        end else begin
            rx_push_o       <= 1'b0;
            rx_parity_err_o <= 1'b0;
            rx_frame_err_o  <= 1'b0;
            rx_break_o      <= 1'b0;
            rx_overrun_o    <= 1'b0;
            if (!uart_en_i) begin
                rx_state_q <= RX_IDLE;
            end else begin
                case (rx_state_q)
                    RX_IDLE: begin
                        if (rx_fall) begin
                            rx_state_q  <= RX_START;
                            rx_len_q    <= len_cfg;
                            rx_div_q    <= uart_baudrate_div_i;
                            rx_par_en_q <= uart_parity_bit_i;
                            rx_par_q    <= odd_cfg;
                        end
                    end
                    RX_START: begin
                        if (rx_sample) begin
                            rx_state_q   <= rx_sync2_q ? RX_IDLE : RX_DATA;
                            rx_shift_q   <= '0;
                            rx_bit_cnt_q <= '0;
                            rx_perr_q    <= 1'b0;
                            rx_zero_q    <= 1'b1;
                        end
                    end
                    RX_DATA: begin
                        if (rx_sample) begin
                            rx_shift_q   <= {rx_sync2_q, rx_shift_q[DATA_UART-1:1]};
                            rx_par_q     <= rx_par_q ^ rx_sync2_q;
                            rx_zero_q    <= rx_zero_q && !rx_sync2_q;
                            rx_bit_cnt_q <= rx_bit_cnt_q + LEN_W'(1);
                            if (rx_bit_cnt_q + LEN_W'(1) == rx_len_q)
                                rx_state_q <= rx_par_en_q ? RX_PARITY : RX_STOP;
                        end
                    end
                    RX_PARITY: begin
                        if (rx_sample) begin
                            rx_perr_q  <= rx_sync2_q ^ rx_par_q;
                            rx_zero_q  <= rx_zero_q && !rx_sync2_q;
                            rx_state_q <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        if (rx_sample) begin
                            // Short frames sit in the top bits; shift down to right-align.
                            rx_data_o       <= rx_shift_q >> (DATA_UART - int'(rx_len_q));
                            rx_push_o       <= !rx_full_i;
                            rx_overrun_o    <= rx_full_i;
                            rx_parity_err_o <= rx_par_en_q && rx_perr_q;
                            rx_frame_err_o  <= !rx_sync2_q;
                            rx_break_o      <= rx_zero_q && !rx_sync2_q;
                            rx_state_q      <= rx_sync2_q ? RX_IDLE : RX_WAIT_IDLE;
                        end
                    end
                    RX_WAIT_IDLE: begin
                        if (rx_sync2_q) rx_state_q <= RX_IDLE;
                    end
                    default: rx_state_q <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_controller.sv
// tb/tb_uart_frame_controller.sv - directed self-checking bench for uart_frame_controller
module tb_uart_frame_controller;
    localparam int BIT = 64;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic [3:0]  len;
    logic        stop2, par_en, par_mode;
    logic [15:0] div;
    logic        rx_line, tx_line;
    logic        load;
    logic [7:0]  txd;
    logic        pull, busy, full;
    logic [7:0]  rxd;
    logic        push, perr, ferr, brk, ovr;

    int checks = 0;
    int errors = 0;
    int pull_cnt = 0, push_cnt = 0, perr_cnt = 0, ferr_cnt = 0, brk_cnt = 0, ovr_cnt = 0;
    logic [7:0] last_data = '0;
    logic       last_push = 1'b0, last_perr = 1'b0, last_ferr = 1'b0, last_brk = 1'b0;

    always #5 clk = ~clk;

    uart_frame_controller dut (
        .clk_i                  (clk),
        .rstn_i                 (rstn),
        .uart_en_i              (en),
        .uart_data_len_i        (len),
        .uart_stop_bits_i       (stop2),
        .uart_parity_bit_i      (par_en),
        .uart_parity_bit_mode_i (par_mode),
        .uart_baudrate_div_i    (div),
        .uart_rx_i              (rx_line),
        .uart_tx_o              (tx_line),
        .tx_load_i              (load),
        .tx_data_i              (txd),
        .tx_pull_o              (pull),
        .tx_busy_o              (busy),
        .rx_full_i              (full),
        .rx_data_o              (rxd),
        .rx_push_o              (push),
        .rx_parity_err_o        (perr),
        .rx_frame_err_o         (ferr),
        .rx_break_o             (brk),
        .rx_overrun_o           (ovr)
    );

    always @(negedge clk) begin
        if (pull === 1'b1) pull_cnt <= pull_cnt + 1;
        if (push === 1'b1) push_cnt <= push_cnt + 1;
        if (perr === 1'b1) perr_cnt <= perr_cnt + 1;
        if (ferr === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if (brk === 1'b1) brk_cnt <= brk_cnt + 1;
        if (ovr === 1'b1) ovr_cnt <= ovr_cnt + 1;
        if ((push | perr | ferr | brk | ovr) === 1'b1) begin
            last_data <= rxd;
            last_push <= push;
            last_perr <= perr;
            last_ferr <= ferr;
            last_brk  <= brk;
        end
    end

    function automatic int strobe_total();
        return push_cnt + perr_cnt + ferr_cnt + brk_cnt + ovr_cnt;
    endfunction

    // Called in the pull cycle; samples the line at each bit midpoint until busy drops.
    task automatic capture_tx(input int max_cycles, output int busy_len,
                              output logic [31:0] bits, output int pull2_at);
        int cnt = 0;
        bits     = '0;
        pull2_at = -1;
        while (busy === 1'b1 && cnt < max_cycles) begin
            if (cnt % BIT == BIT / 2 && cnt / BIT < 32) bits[cnt / BIT] = tx_line;
            if (cnt > 0 && pull === 1'b1) begin
                pull2_at = cnt;
                load     = 1'b0;
            end
            @(negedge clk);
            cnt++;
        end
        busy_len = cnt;
    endtask

    task automatic rx_send(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_line = bits[i];
            repeat (BIT) @(negedge clk);
        end
        rx_line = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b1; len = 4'd8; stop2 = 1'b0; par_en = 1'b0; par_mode = 1'b0;
        div = 16'd4; rx_line = 1'b1; load = 1'b0; txd = '0; full = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (tx_line !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx_line); end
        checks++;
        if ({pull, busy, push, perr, ferr, brk, ovr} !== 7'b0) begin
            errors++; $display("FAIL reset_strobes got %b want 0000000", {pull, busy, push, perr, ferr, brk, ovr});
        end
        checks++;
        if (rxd !== 8'h00) begin errors++; $display("FAIL reset_rxdata got %h want 00", rxd); end
        rstn = 1'b1;
        repeat (10000) @(negedge clk);
        checks++;
        if (pull_cnt !== 0) begin errors++; $display("FAIL idle_pull got %0d want 0", pull_cnt); end
        checks++;
        if (strobe_total() !== 0) begin errors++; $display("FAIL idle_rx_strobes got %0d want 0", strobe_total()); end
        checks++;
        if (tx_line !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_line got tx=%b busy=%b want tx=1 busy=0", tx_line, busy);
        end
    endtask

    task automatic test_tx_8n1();
        int p0, blen, p2;
        logic [31:0] bits;
        logic [9:0]  exp_bits;
        exp_bits = {1'b1, 8'hA5, 1'b0};
        len = 4'd8; par_en = 1'b0; stop2 = 1'b0; div = 16'd4;
        p0 = pull_cnt;
        txd = 8'hA5; load = 1'b1;
        @(negedge clk);
        checks++;
        if (pull !== 1'b1 || tx_line !== 1'b0) begin
            errors++; $display("FAIL tx_first_cycle got pull=%b tx=%b want pull=1 tx=0", pull, tx_line);
        end
        load = 1'b0;
        capture_tx(2000, blen, bits, p2);
        checks++;
        if (bits[9:0] !== exp_bits) begin errors++; $display("FAIL tx_8n1_bits got %b want %b", bits[9:0], exp_bits); end
        checks++;
        if (blen !== 640) begin errors++; $display("FAIL tx_8n1_busy got %0d want 640", blen); end
        repeat (4) @(negedge clk);
        checks++;
        if (pull_cnt - p0 !== 1) begin errors++; $display("FAIL tx_8n1_pulls got %0d want 1", pull_cnt - p0); end
    endtask

    task automatic test_back_to_back();
        int p0, blen, p2;
        logic [31:0] bits;
        logic [21:0] exp_bits;
        exp_bits = {2'b11, 1'b1, 7'h0F, 1'b0, 2'b11, 1'b1, 7'h55, 1'b0};
        len = 4'd7; par_en = 1'b1; par_mode = 1'b1; stop2 = 1'b1;
        p0 = pull_cnt;
        txd = 8'h55; load = 1'b1;
        @(negedge clk);
        checks++;
        if (pull !== 1'b1) begin errors++; $display("FAIL b2b_first_pull got %b want 1", pull); end
        txd = 8'h0F;
        capture_tx(3000, blen, bits, p2);
        load = 1'b0;
        checks++;
        if (p2 !== 704) begin errors++; $display("FAIL b2b_second_pull got %0d want 704", p2); end
        checks++;
        if (bits[21:0] !== exp_bits) begin errors++; $display("FAIL b2b_bits got %b want %b", bits[21:0], exp_bits); end
        checks++;
        if (blen !== 1408) begin errors++; $display("FAIL b2b_busy got %0d want 1408", blen); end
        repeat (4) @(negedge clk);
        checks++;
        if (pull_cnt - p0 !== 2) begin errors++; $display("FAIL b2b_pulls got %0d want 2", pull_cnt - p0); end
    endtask

    task automatic test_len_clamp();
        int blen, p2;
        logic [31:0] bits;
        logic [6:0]  exp_bits;
        exp_bits = {1'b1, 5'h1F, 1'b0};
        len = 4'd2; par_en = 1'b0; par_mode = 1'b0; stop2 = 1'b0;
        txd = 8'hFF; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        capture_tx(2000, blen, bits, p2);
        checks++;
        if (blen !== 448) begin errors++; $display("FAIL clamp_busy got %0d want 448", blen); end
        checks++;
        if (bits[6:0] !== exp_bits) begin errors++; $display("FAIL clamp_bits got %b want %b", bits[6:0], exp_bits); end
    endtask

    task automatic test_disable();
        int p0;
        len = 4'd8;
        p0 = pull_cnt;
        txd = 8'h00; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (100) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_line !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL disable_abort got tx=%b busy=%b want tx=1 busy=0", tx_line, busy);
        end
        repeat (200) @(negedge clk);
        en = 1'b1;
        repeat (1000) @(negedge clk);
        checks++;
        if (pull_cnt - p0 !== 1 || tx_line !== 1'b1) begin
            errors++; $display("FAIL disable_idle got pulls=%0d tx=%b want pulls=1 tx=1", pull_cnt - p0, tx_line);
        end
    endtask

    task automatic test_rx_parity();
        int p0, f0;
        len = 4'd7; par_en = 1'b1; par_mode = 1'b0; stop2 = 1'b0;
        p0 = push_cnt; f0 = ferr_cnt;
        rx_send({22'd0, 1'b1, 1'b1, 7'h41, 1'b0}, 10);
        repeat (BIT) @(negedge clk);
        checks++;
        if (push_cnt - p0 !== 1) begin errors++; $display("FAIL rx7e1_pushes got %0d want 1", push_cnt - p0); end
        checks++;
        if (last_data !== 8'h41) begin errors++; $display("FAIL rx7e1_data got %h want 41", last_data); end
        checks++;
        if ({last_push, last_perr} !== 2'b11) begin
            errors++; $display("FAIL rx7e1_parity got push=%b perr=%b want 1 1", last_push, last_perr);
        end
        checks++;
        if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL rx7e1_frame got %0d want 0", ferr_cnt - f0); end
    endtask

    task automatic test_rx_break();
        int p0, b0, f0;
        len = 4'd8; par_en = 1'b0;
        p0 = push_cnt; b0 = brk_cnt; f0 = ferr_cnt;
        rx_line = 1'b0;
        repeat (12 * BIT) @(negedge clk);
        checks++;
        if (brk_cnt - b0 !== 1 || ferr_cnt - f0 !== 1 || push_cnt - p0 !== 1) begin
            errors++; $display("FAIL break_counts got brk=%0d ferr=%0d push=%0d want 1 1 1",
                               brk_cnt - b0, ferr_cnt - f0, push_cnt - p0);
        end
        checks++;
        if (last_data !== 8'h00 || {last_ferr, last_brk} !== 2'b11) begin
            errors++; $display("FAIL break_frame got data=%h ferr=%b brk=%b want 00 1 1", last_data, last_ferr, last_brk);
        end
        rx_line = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        rx_send({22'd0, 1'b1, 8'h3C, 1'b0}, 10);
        repeat (BIT) @(negedge clk);
        checks++;
        if (push_cnt - p0 !== 2 || brk_cnt - b0 !== 1) begin
            errors++; $display("FAIL break_recover_counts got push=%0d brk=%0d want 2 1", push_cnt - p0, brk_cnt - b0);
        end
        checks++;
        if (last_data !== 8'h3C || {last_ferr, last_brk} !== 2'b00) begin
            errors++; $display("FAIL break_recover_frame got data=%h ferr=%b brk=%b want 3c 0 0", last_data, last_ferr, last_brk);
        end
    endtask

    task automatic test_rx_overrun();
        int p0, o0;
        p0 = push_cnt; o0 = ovr_cnt;
        full = 1'b1;
        rx_send({22'd0, 1'b1, 8'h99, 1'b0}, 10);
        repeat (BIT) @(negedge clk);
        full = 1'b0;
        checks++;
        if (ovr_cnt - o0 !== 1 || push_cnt - p0 !== 0) begin
            errors++; $display("FAIL overrun_counts got ovr=%0d push=%0d want 1 0", ovr_cnt - o0, push_cnt - p0);
        end
        checks++;
        if (rxd !== 8'h99) begin errors++; $display("FAIL overrun_data got %h want 99", rxd); end
    endtask

    task automatic test_rx_glitch();
        int s0, p0;
        s0 = strobe_total(); p0 = push_cnt;
        rx_line = 1'b0;
        repeat (16) @(negedge clk);
        rx_line = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        checks++;
        if (strobe_total() !== s0) begin errors++; $display("FAIL glitch_strobes got %0d want %0d", strobe_total(), s0); end
        rx_send({22'd0, 1'b1, 8'h5A, 1'b0}, 10);
        repeat (BIT) @(negedge clk);
        checks++;
        if (push_cnt - p0 !== 1 || last_data !== 8'h5A) begin
            errors++; $display("FAIL glitch_next_frame got push=%0d data=%h want 1 5a", push_cnt - p0, last_data);
        end
    endtask

    initial begin
        test_reset();
        test_tx_8n1();
        test_back_to_back();
        test_len_clamp();
        test_disable();
        test_rx_parity();
        test_rx_break();
        test_rx_overrun();
        test_rx_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
